// File: rtl/opk_pkg.sv
// -----------------------------------------------------------------------------
// opk_pkg
// Shared definitions for the pulse arbiter: FSM state encoding and the width
// of the PULSE/HOLD (and debounce) counters.
// -----------------------------------------------------------------------------
package opk_pkg;

    // Width of the PULSE/HOLD dwell counter and the debounce counter.
    localparam int unsigned OPK_CNT_W = 16;

    typedef enum logic [1:0] {
        OPK_IDLE  = 2'd0,
        OPK_PULSE = 2'd1,
        OPK_HOLD  = 2'd2
    } opk_state_e;

endpackage

// File: rtl/opk_key_sync.sv
// -----------------------------------------------------------------------------
// opk_key_sync
// Per-key front end: 2-flop synchronizer, optional debounce filter and a
// registered falling-edge detector. The filter is built only when the macro
// OPK_ARB_DEBOUNCE_EN is defined.
//
// Ports
//   clkg    : clock, rising edge
//   rst     : asynchronous active-low reset
//   key_raw : asynchronous active-low button, 1 = released
//   fall    : one-clock pulse, 1 when the (filtered) level went 1 -> 0
// -----------------------------------------------------------------------------
module opk_key_sync
    import opk_pkg::*;
`ifdef OPK_ARB_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_LEN = 16
)
`endif
(
    input  logic clkg,
    input  logic rst,
    input  logic key_raw,
    output logic fall
);

    // sync_q[0] is the metastability stage, sync_q[1] the usable level.
    logic [1:0] sync_q;
    logic       level;
    logic       prev_q;
    logic       fall_q;

    always_ff @(posedge clkg or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

`ifdef OPK_ARB_DEBOUNCE_EN
    localparam logic [OPK_CNT_W-1:0] DB_LAST = OPK_CNT_W'(DEBOUNCE_LEN - 1);

    logic                 flt_q;
    logic                 flt_d;
    logic [OPK_CNT_W-1:0] db_cnt_q;
    logic [OPK_CNT_W-1:0] db_cnt_d;

    // The filtered level follows only after the synchronized level has
    // disagreed with it for DEBOUNCE_LEN consecutive clocks.
    always_comb begin
        flt_d    = flt_q;
        db_cnt_d = '0;
        if (sync_q[1] != flt_q) begin
            if (db_cnt_q == DB_LAST) begin
                flt_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clkg or negedge rst) begin
        if (!rst) begin
            flt_q    <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            flt_q    <= flt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level = flt_q;
`else
    assign level = sync_q[1];
`endif

    // Registered edge so the request lands in pending one clock later.
    always_ff @(posedge clkg or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            prev_q <= level;
            fall_q <= prev_q & ~level;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/opk_pulse_arbiter.sv
// -----------------------------------------------------------------------------
// opk_pulse_arbiter
// Shares one active-low one-shot among N_KEYS push buttons. Each press latches
// a pending request; an IDLE/PULSE/HOLD FSM serves requests round-robin,
// driving pulse low for PULSE_LEN clocks followed by HOLDOFF clocks of dead
// time. Optional debounce filtering is enabled by defining OPK_ARB_DEBOUNCE_EN.
//
// Ports
//   clkg     : clock, rising edge
//   rst      : asynchronous active-low reset
//   key      : N_KEYS async active-low buttons, 1 = released
//   pulse    : shared one-shot, active low, idle 1 (registered)
//   grant_id : index of the key owning the current / last pulse (registered)
//   busy     : 1 while in PULSE or HOLD (registered)
//   pending  : latched requests not yet served
// -----------------------------------------------------------------------------
module opk_pulse_arbiter
    import opk_pkg::*;
#(
    parameter int unsigned N_KEYS       = 4,
    parameter int unsigned PULSE_LEN    = 1,
    parameter int unsigned HOLDOFF      = 99,
    parameter int unsigned DEBOUNCE_LEN = 16
) (
    input  logic                      clkg,
    input  logic                      rst,
    input  logic [N_KEYS-1:0]         key,
    output logic                      pulse,
    output logic [$clog2(N_KEYS)-1:0] grant_id,
    output logic                      busy,
    output logic [N_KEYS-1:0]         pending
);

    localparam int unsigned ID_W = $clog2(N_KEYS);
    localparam logic [OPK_CNT_W-1:0] PULSE_LAST = OPK_CNT_W'(PULSE_LEN - 1);
    localparam logic [OPK_CNT_W-1:0] HOLD_LAST  = OPK_CNT_W'(HOLDOFF - 1);

    // Elaboration-time parameter range checks.
    if (N_KEYS < 2 || N_KEYS > 8) begin : g_bad_n_keys
        $error("opk_pulse_arbiter: N_KEYS must be 2..8");
    end
    if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
        $error("opk_pulse_arbiter: PULSE_LEN must be 1..255");
    end
    if (HOLDOFF < 1 || HOLDOFF > 65535) begin : g_bad_holdoff
        $error("opk_pulse_arbiter: HOLDOFF must be 1..65535");
    end
    if (DEBOUNCE_LEN < 1 || DEBOUNCE_LEN > 65535) begin : g_bad_debounce_len
        $error("opk_pulse_arbiter: DEBOUNCE_LEN must be 1..65535");
    end

    // ---------------------------------------------------------------------
    // Key front ends
    // ---------------------------------------------------------------------
    logic [N_KEYS-1:0] key_fall;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        opk_key_sync
`ifdef OPK_ARB_DEBOUNCE_EN
        #(
            .DEBOUNCE_LEN (DEBOUNCE_LEN)
        )
`endif
        u_key_sync (
            .clkg    (clkg),
            .rst     (rst),
            .key_raw (key[g]),
            .fall    (key_fall[g])
        );
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    opk_state_e           state_q, state_d;
    logic [OPK_CNT_W-1:0] cnt_q, cnt_d;
    logic                 pulse_q, pulse_d;
    logic                 busy_q, busy_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    // rr_ptr_q is the index with top priority at the next arbitration.
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [N_KEYS-1:0]    pending_q, pending_d;
    logic [N_KEYS-1:0]    clr;

    // ---------------------------------------------------------------------
    // Round-robin winner search starting at rr_ptr_q
    // ---------------------------------------------------------------------
    logic            win_found;
    logic [ID_W-1:0] win_id;
    int unsigned     idx;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= N_KEYS) begin
                idx = idx - N_KEYS;
            end
            if (!win_found && pending_q[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state and registered outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        clr      = '0;

        case (state_q)
            OPK_IDLE: begin
                if (win_found) begin
                    state_d = OPK_PULSE;
                    grant_d = win_id;
                    clr     = N_KEYS'(1) << win_id;
                    if (win_id == ID_W'(N_KEYS - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = win_id + 1'b1;
                    end
                end
            end
            OPK_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = OPK_HOLD;
                end
            end
            OPK_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = OPK_IDLE;
                end
            end
            default: begin
                state_d = OPK_IDLE;
            end
        endcase

        // Counter restarts from 0 on every state entry and rests in IDLE.
        if (state_d != state_q || state_q == OPK_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs are decoded from the next state so they come straight off flops.
        pulse_d = (state_d != OPK_PULSE);
        busy_d  = (state_d != OPK_IDLE);

        // A new edge in the same cycle as the grant clear keeps the bit set.
        pending_d = (pending_q & ~clr) | key_fall;
    end

    always_ff @(posedge clkg or negedge rst) begin
        if (!rst) begin
            state_q   <= OPK_IDLE;
            cnt_q     <= '0;
            pulse_q   <= 1'b1;
            busy_q    <= 1'b0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
        end
    end

    assign pulse    = pulse_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_opk_pulse_arbiter.sv
// -----------------------------------------------------------------------------
// tb_opk_pulse_arbiter
// Scoreboard bench: stimulus pushes the expected pulse (owner, start cycle)
// into a queue; a monitor pops and compares whenever the DUT starts a pulse,
// and also checks every pulse width and busy window. A second instance with
// PULSE_LEN=4 is used for the asynchronous reset case. Honours
// OPK_ARB_DEBOUNCE_EN for the debounce cases.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_opk_pulse_arbiter;

    localparam int PLEN = 1;
    localparam int HOLD = 99;
`ifdef OPK_ARB_DEBOUNCE_EN
    localparam int DB = 16;
    localparam int D4 = 1;
`else
    localparam int DB = 0;
    localparam int D4 = 0;
`endif
    localparam int LAT = 4 + DB;

    logic       clkg = 1'b0;
    logic       rst  = 1'b0;
    logic [3:0] key  = 4'hf;
    logic       pulse;
    logic [1:0] grant_id;
    logic       busy;
    logic [3:0] pending;

    logic       rst4 = 1'b0;
    logic [3:0] key4 = 4'hf;
    logic       pulse4;
    logic [1:0] grant4;
    logic       busy4;
    logic [3:0] pending4;

    opk_pulse_arbiter #(
        .N_KEYS       (4),
        .PULSE_LEN    (PLEN),
        .HOLDOFF      (HOLD),
        .DEBOUNCE_LEN (16)
    ) u_dut (
        .clkg     (clkg),
        .rst      (rst),
        .key      (key),
        .pulse    (pulse),
        .grant_id (grant_id),
        .busy     (busy),
        .pending  (pending)
    );

    opk_pulse_arbiter #(
        .N_KEYS       (4),
        .PULSE_LEN    (4),
        .HOLDOFF      (10),
        .DEBOUNCE_LEN (1)
    ) u_dut4 (
        .clkg     (clkg),
        .rst      (rst4),
        .key      (key4),
        .pulse    (pulse4),
        .grant_id (grant4),
        .busy     (busy4),
        .pending  (pending4)
    );

    always #5 clkg = ~clkg;

    int cyc = 0;
    always @(posedge clkg) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clkg);
    endtask

    typedef struct {
        int id;
        int at;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    bit   mon_en     = 1'b0;
    logic prev_pulse = 1'b1;
    logic prev_busy  = 1'b0;
    int   low_len    = 0;
    int   busy_len   = 0;

    always @(negedge clkg) begin
        if (mon_en) begin
            if (pulse === 1'b0 && prev_pulse === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: grant %0d at cycle %0d, expected none",
                             grant_id, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_grant", int'(grant_id), e.id);
                    check("pulse_cycle", cyc, e.at);
                end
                low_len = 1;
            end else if (pulse === 1'b0) begin
                low_len++;
            end
            if (pulse === 1'b1 && prev_pulse === 1'b0) begin
                check("pulse_width", low_len, PLEN);
            end

            if (busy === 1'b1 && prev_busy !== 1'b1) begin
                busy_len = 1;
            end else if (busy === 1'b1) begin
                busy_len++;
            end
            if (busy === 1'b0 && prev_busy === 1'b1) begin
                check("busy_width", busy_len, PLEN + HOLD);
            end

            prev_pulse = pulse;
            prev_busy  = busy;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    int k;
    int k2;

    initial begin
        repeat (3) @(negedge clkg);
        check("rst_pulse", int'(pulse), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_grant", int'(grant_id), 0);
        check("rst_pending", int'(pending), 0);
        rst    = 1'b1;
        rst4   = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clkg);

`ifndef OPK_ARB_DEBOUNCE_EN
        // Single press on key 0.
        k = cyc + 1;
        key[0] = 1'b0;
        exp_q.push_back('{0, k + LAT});
        wait_to(k + 1);
        key[0] = 1'b1;
        wait_to(k + LAT);
        check("t1_busy", int'(busy), 1);
        check("t1_pending", int'(pending), 0);
        wait_to(k + 115);

        // Keys 1 and 3 on the same edge.
        k = cyc + 1;
        key[1] = 1'b0;
        key[3] = 1'b0;
        exp_q.push_back('{1, k + 4});
        exp_q.push_back('{3, k + 105});
        wait_to(k + 3);
        check("t2_pending_a", int'(pending), 4'b1010);
        wait_to(k + 4);
        check("t2_pending_b", int'(pending), 4'b1000);
        wait_to(k + 5);
        key[1] = 1'b1;
        key[3] = 1'b1;
        wait_to(k + 104);
        check("t2_pending_c", int'(pending), 4'b1000);
        wait_to(k + 106);
        check("t2_pending_d", int'(pending), 4'b0000);
        wait_to(k + 220);

        // Key 2 held 500 clocks, then released and pressed again.
        k = cyc + 1;
        key[2] = 1'b0;
        exp_q.push_back('{2, k + 4});
        wait_to(k + 250);
        check("t3_no_retrigger", int'(pending), 0);
        wait_to(k + 499);
        key[2] = 1'b1;
        wait_to(k + 510);
        k2 = cyc + 1;
        key[2] = 1'b0;
        exp_q.push_back('{2, k2 + 4});
        wait_to(k2 + 2);
        key[2] = 1'b1;
        wait_to(k2 + 115);

        // Key 0 pressed (twice) during HOLD: one extra pulse after HOLD.
        k = cyc + 1;
        key[0] = 1'b0;
        exp_q.push_back('{0, k + 4});
        wait_to(k + 2);
        key[0] = 1'b1;
        wait_to(k + 29);
        key[0] = 1'b0;
        wait_to(k + 36);
        check("t4_pending_a", int'(pending), 4'b0001);
        check("t4_busy", int'(busy), 1);
        wait_to(k + 39);
        key[0] = 1'b1;
        wait_to(k + 49);
        key[0] = 1'b0;
        wait_to(k + 59);
        key[0] = 1'b1;
        exp_q.push_back('{0, k + 105});
        wait_to(k + 80);
        check("t4_pending_b", int'(pending), 4'b0001);
        wait_to(k + 104);
        check("t4_pending_c", int'(pending), 4'b0001);
        check("t4_idle", int'(busy), 0);
        wait_to(k + 105);
        check("t4_pending_d", int'(pending), 4'b0000);
        wait_to(k + 220);
`else
        // 10-clock glitch must be filtered out.
        k = cyc + 1;
        key[0] = 1'b0;
        wait_to(k + 9);
        key[0] = 1'b1;
        wait_to(k + 60);
        check("db_glitch_pending", int'(pending), 0);
        check("db_glitch_busy", int'(busy), 0);

        // 20-clock press gives one pulse, 16 clocks later than unfiltered.
        k = cyc + 1;
        key[1] = 1'b0;
        exp_q.push_back('{1, k + LAT});
        wait_to(k + 18);
        check("db_pending_a", int'(pending), 0);
        wait_to(k + 19);
        check("db_pending_b", int'(pending), 4'b0010);
        key[1] = 1'b1;
        wait_to(k + 21);
        check("db_pending_c", int'(pending), 0);
        wait_to(k + 140);
`endif

        // Asynchronous reset in the middle of a 4-clock pulse.
        k = cyc + 1;
        key4[1] = 1'b0;
        @(negedge clkg);
        key4[2] = 1'b0;
        wait_to(k + 5 + D4);
        check("r_pulse_low", int'(pulse4), 0);
        check("r_busy", int'(busy4), 1);
        check("r_grant", int'(grant4), 1);
        check("r_pending", int'(pending4), 4'b0100);
        #1 rst4 = 1'b0;
        #1;
        check("r_async_pulse", int'(pulse4), 1);
        check("r_async_pending", int'(pending4), 0);
        check("r_async_busy", int'(busy4), 0);
        check("r_async_grant", int'(grant4), 0);
        key4 = 4'hf;
        repeat (3) @(negedge clkg);
        rst4 = 1'b1;
        repeat (20) @(negedge clkg);
        check("r_after_pulse", int'(pulse4), 1);
        check("r_after_pending", int'(pending4), 0);

        repeat (5) @(negedge clkg);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
